imem_loader: RTL and testbench

- Writer-side master for the instruction memory's external load port (`imem_ncs` / `imem_nwr` / `imem_din`).
- Receives a length-prefixed little-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Holds the CPU in `halting` for the whole load; sits beside the cpu top-level, between a host byte source and the fetch stage's memory.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte stream
// into 32-bit words and writes them to consecutive addresses, holding the CPU halted.
module imem_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_ncs,
   output logic              imem_nwr,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_din,
   output logic              halting,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CW = ADDR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_COLLECT, S_WRITE} state_t;

   state_t        state;
   logic [CW-1:0] word_cnt;
   logic [CW-1:0] n_words;
   logic [1:0]    byte_cnt;
   logic [7:0]    len_lo;
   logic [23:0]   asm_lo;
   logic [15:0]   n_full;
   logic          xfer;
   logic          len_bad;

   assign xfer    = byte_valid & byte_ready;
   assign n_full  = {byte_data, len_lo};
   assign len_bad = (n_full == 16'd0) || (32'(n_full) > MAX_WORDS);

   // Byte lanes 0..2 are held here; lane 3 goes straight into imem_din on the last transfer.
   always_ff @(posedge clk) begin
      if (xfer && state == S_LEN_LO)
         len_lo <= byte_data;
      if (xfer && state == S_COLLECT && byte_cnt != 2'd3)
         asm_lo[{byte_cnt, 3'b000} +: 8] <= byte_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         word_cnt   <= '0;
         n_words    <= '0;
         byte_cnt   <= '0;
         byte_ready <= 1'b0;
         imem_ncs   <= 1'b1;
         imem_nwr   <= 1'b1;
         imem_addr  <= '0;
         imem_din   <= '0;
         halting    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_LEN_LO;
                  halting    <= 1'b1;
                  busy       <= 1'b1;
                  err        <= 1'b0;
                  word_cnt   <= '0;
                  byte_cnt   <= '0;
                  byte_ready <= 1'b1;
               end
            end
            S_LEN_LO: begin
               if (xfer)
                  state <= S_LEN_HI;
            end
            S_LEN_HI: begin
               if (xfer) begin
                  if (len_bad) begin
                     state      <= S_IDLE;
                     err        <= 1'b1;
                     halting    <= 1'b0;
                     busy       <= 1'b0;
                     byte_ready <= 1'b0;
                  end else begin
                     state   <= S_COLLECT;
                     n_words <= n_full[CW-1:0];
                  end
               end
            end
            S_COLLECT: begin
               if (xfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state      <= S_WRITE;
                     byte_ready <= 1'b0;
                     imem_ncs   <= 1'b0;
                     imem_nwr   <= 1'b0;
                     imem_addr  <= word_cnt[ADDR_W-1:0];
                     imem_din   <= {byte_data, asm_lo};
                  end
               end
            end
            S_WRITE: begin
               imem_ncs <= 1'b1;
               imem_nwr <= 1'b1;
               word_cnt <= word_cnt + CW'(1);
               byte_cnt <= '0;
               if (word_cnt == n_words - CW'(1)) begin
                  state   <= S_IDLE;
                  done    <= 1'b1;
                  halting <= 1'b0;
                  busy    <= 1'b0;
               end else begin
                  state      <= S_COLLECT;
                  byte_ready <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams push expected writes and
// completion events; a negedge monitor pops and compares as the loader produces them.
module tb_imem_loader;

   localparam int ADDR_W = 10;
   localparam logic [1:0] EV_WR = 2'd0, EV_DONE = 2'd1, EV_ERR = 2'd2;

   typedef struct packed {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } ev_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = 8'h00;
   logic              byte_ready;
   logic              imem_ncs;
   logic              imem_nwr;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_din;
   logic              halting;
   logic              busy;
   logic              done;
   logic              err;

   int  checks = 0;
   int  errors = 0;
   ev_t exp_q[$];
   logic strobe_prev = 1'b0;
   logic err_prev = 1'b0;

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(1024)) dut (
      .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .imem_ncs(imem_ncs),
      .imem_nwr(imem_nwr), .imem_addr(imem_addr), .imem_din(imem_din),
      .halting(halting), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic pop_check(input logic [1:0] kind, input logic [ADDR_W-1:0] addr,
                            input logic [31:0] data);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%h, expected none", kind, addr, data);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== kind || (kind == EV_WR && (e.addr !== addr || e.data !== data))) begin
            errors++;
            $display("FAIL event: got kind=%0d addr=%0d data=%h expected kind=%0d addr=%0d data=%h",
                     kind, addr, data, e.kind, e.addr, e.data);
         end
      end
   endtask

   always @(negedge clk) begin
      logic strobe;
      strobe = !imem_ncs || !imem_nwr;
      if (strobe) begin
         check("strobe_pair", {63'd0, imem_ncs}, {63'd0, imem_nwr});
         if (strobe_prev) begin
            checks++; errors++;
            $display("FAIL strobe_width: strobe low for 2 cycles at addr %0d, expected 1", imem_addr);
         end
         pop_check(EV_WR, imem_addr, imem_din);
      end
      if (done === 1'b1) begin
         if (err === 1'b1) begin
            checks++; errors++;
            $display("FAIL done_err: done=1 err=1 together, expected exclusive");
         end
         pop_check(EV_DONE, '0, '0);
      end
      if (err === 1'b1 && err_prev !== 1'b1)
         pop_check(EV_ERR, '0, '0);
      strobe_prev = strobe;
      err_prev    = err;
   end

   function automatic ev_t wr(input int a, input logic [31:0] d);
      ev_t e;
      e.kind = EV_WR; e.addr = ADDR_W'(a); e.data = d;
      return e;
   endfunction

   function automatic ev_t ev(input logic [1:0] k);
      ev_t e;
      e.kind = k; e.addr = '0; e.data = '0;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge following the transfer edge.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (byte_ready !== 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         $display("FAIL byte_timeout: byte_ready never rose, expected 1");
         $fatal(1, "timeout");
      end
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (busy === 1'b1 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 2000) begin
         errors++;
         $display("FAIL idle_timeout: busy stuck at 1, expected 0");
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string name);
      check(name, {27'd0, byte_ready, imem_ncs, imem_nwr, imem_addr, imem_din, halting, busy, done, err},
            {27'd0, 1'b0, 1'b1, 1'b1, 10'd0, 32'd0, 4'b0000});
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_vals("reset_values");
      rst = 1'b0;
      @(negedge clk);

      // N=2 continuous, with start pulses mid-load that must be ignored
      exp_q.push_back(wr(0, 32'h00A00513));
      exp_q.push_back(wr(1, 32'h00100593));
      exp_q.push_back(ev(EV_DONE));
      pulse_start();
      check("halting_after_start", {63'd0, halting}, 64'd1);
      check("busy_after_start", {63'd0, busy}, 64'd1);
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      pulse_start();
      send_byte(8'h05, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
      send_word(32'h00100593, 0);
      pulse_start();
      wait_idle();
      check("halting_after_done", {63'd0, halting}, 64'd0);

      // Same stream with 3-cycle gaps between bytes
      exp_q.push_back(wr(0, 32'h00A00513));
      exp_q.push_back(wr(1, 32'h00100593));
      exp_q.push_back(ev(EV_DONE));
      pulse_start();
      send_byte(8'h02, 3); send_byte(8'h00, 3);
      send_word(32'h00A00513, 3);
      send_word(32'h00100593, 3);
      wait_idle();

      // Zero-length header
      exp_q.push_back(ev(EV_ERR));
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      check("err_zero_len", {63'd0, err}, 64'd1);
      check("halting_zero_len", {63'd0, halting}, 64'd0);

      // start coincident with a valid byte in IDLE: byte is only consumed as LEN_LO
      exp_q.push_back(wr(0, 32'hCAFE0001));
      exp_q.push_back(ev(EV_DONE));
      byte_valid = 1'b1;
      byte_data  = 8'h01;
      start      = 1'b1;
      check("ready_in_idle", {63'd0, byte_ready}, 64'd0);
      @(negedge clk);
      start = 1'b0;
      check("err_cleared", {63'd0, err}, 64'd0);
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_word(32'hCAFE0001, 0);
      wait_idle();

      // Oversized header, then the largest legal program
      exp_q.push_back(ev(EV_ERR));
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h04, 0);
      check("err_too_long", {63'd0, err}, 64'd1);
      for (int k = 0; k < 1024; k++) exp_q.push_back(wr(k, 32'(k)));
      exp_q.push_back(ev(EV_DONE));
      pulse_start();
      send_byte(8'h00, 0); send_byte(8'h04, 0);
      for (int k = 0; k < 1024; k++) send_word(32'(k), 0);
      wait_idle();

      // Asynchronous reset after 6 bytes (first word already written)
      exp_q.push_back(wr(0, 32'h00A00513));
      pulse_start();
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_word(32'h00A00513, 0);
      #1 rst = 1'b1;
      #1 check_reset_vals("async_reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(wr(0, 32'hDEADBEEF));
      exp_q.push_back(ev(EV_DONE));
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_word(32'hDEADBEEF, 0);
      wait_idle();

      check("events_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
